// File: rtl/l2_ctrl_pkg.sv
// Shared types and default sizing for the layer-2 sequencing controller.
package l2_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DRAIN,
    DONE
  } l2_seq_state_t;

  localparam int unsigned L2_N_IN_DEF     = 100;
  localparam int unsigned L2_N_OUT_DEF    = 25;
  localparam int unsigned L2_WDOG_CYC_DEF = 32;

endpackage

// File: rtl/sat_cnt7.sv
// 7-bit counter with synchronous clear, increment and saturation at MAX.
module sat_cnt7 #(
  parameter int unsigned MAX = 127
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [6:0] cnt,
  output logic       full_nxt
);

  localparam logic [6:0] MAX7 = 7'(MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX7)) begin
      cnt <= cnt + 7'd1;
    end
  end

  // Count will equal MAX after this edge (ignores clr; callers never combine them).
  assign full_nxt = (cnt == MAX7) || (inc && (cnt == MAX7 - 7'd1));

endmodule

// File: rtl/l2_seq_ctrl.sv
// Layer-2 frame sequencer: issues N_IN pairs, waits for N_OUT groups, pulses tx_done.
// Optional watchdog on WAIT enabled by defining L2_SEQ_WDOG_EN.
module l2_seq_ctrl
  import l2_ctrl_pkg::*;
#(
  parameter int unsigned N_IN     = L2_N_IN_DEF,
  parameter int unsigned N_OUT    = L2_N_OUT_DEF,
  parameter int unsigned WDOG_CYC = L2_WDOG_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frm_go,
  input  logic       src_vld,
  output logic       src_ack,
  output logic       l2_strt,
  input  logic       l2_bsy,
  input  logic       out_tk,
  output logic       tx_done,
  output logic       busy,
  output logic [6:0] iss_cnt,
  output logic [6:0] out_cnt,
  output logic       err
);

  if (N_IN < 1 || N_IN > 127 || N_OUT < 1 || N_OUT > 127 ||
      WDOG_CYC < 16 || WDOG_CYC > 255) begin : g_bad_param
    $error("l2_seq_ctrl: parameter out of legal range");
  end

  l2_seq_state_t state;
  logic          seen_bsy;
  logic          issue_go;
  logic          cnt_clr;
  logic          out_inc;
  logic          iss_full;
  logic          out_full_nxt;
  logic          wdog_hit;

  assign issue_go = (state == ISSUE) && src_vld && !l2_bsy;
  assign cnt_clr  = (state == IDLE) && frm_go;
  assign out_inc  = out_tk && (state inside {ISSUE, WAIT, DRAIN});

  // Pulse outputs are pure decodes; only l2_strt/src_ack see inputs, never out_tk.
  assign l2_strt = issue_go;
  assign src_ack = issue_go;
  assign tx_done = (state == DONE);
  assign busy    = (state != IDLE);

  sat_cnt7 #(.MAX(N_IN)) u_iss_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .inc      (issue_go),
    .cnt      (iss_cnt),
    .full_nxt (iss_full)
  );

  sat_cnt7 #(.MAX(N_OUT)) u_out_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .inc      (out_inc),
    .cnt      (out_cnt),
    .full_nxt (out_full_nxt)
  );

`ifdef L2_SEQ_WDOG_EN
  localparam logic [7:0] WDOG_LIM = 8'(WDOG_CYC);
  logic [7:0] wdog;
  logic       err_q;

  assign wdog_hit = (state == WAIT) && (wdog == WDOG_LIM - 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog  <= '0;
      err_q <= 1'b0;
    end else begin
      wdog <= (state == WAIT && !wdog_hit) ? wdog + 8'd1 : '0;
      if (wdog_hit) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign wdog_hit = 1'b0;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      seen_bsy <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (frm_go) begin
            seen_bsy <= 1'b0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_go) state <= WAIT;
        end
        WAIT: begin
          // Datapath must be seen busy before its idle level means "finished".
          if (wdog_hit) begin
            seen_bsy <= 1'b0;
            state    <= DONE;
          end else if (!l2_bsy && seen_bsy) begin
            seen_bsy <= 1'b0;
            state    <= iss_full ? DRAIN : ISSUE;
          end else if (l2_bsy) begin
            seen_bsy <= 1'b1;
          end
        end
        DRAIN: begin
          if (out_full_nxt) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_seq_ctrl.sv
// Self-checking bench for l2_seq_ctrl: per-frame timeline predicted from the
// issue/busy/drain rules, with randomized gaps, busy windows and out_tk traffic.
module tb_l2_seq_ctrl;

  localparam int unsigned N_IN  = 3;
  localparam int unsigned N_OUT = 2;
  localparam int unsigned WDOG  = 16;
  localparam int          HOR   = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frm_go = 1'b0;
  logic       src_vld = 1'b0;
  logic       l2_bsy = 1'b0;
  logic       out_tk = 1'b0;
  logic       src_ack, l2_strt, tx_done, busy, err;
  logic [6:0] iss_cnt, out_cnt;

  int checks = 0;
  int errors = 0;

  l2_seq_ctrl #(
    .N_IN     (N_IN),
    .N_OUT    (N_OUT),
    .WDOG_CYC (WDOG)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .frm_go  (frm_go),
    .src_vld (src_vld),
    .src_ack (src_ack),
    .l2_strt (l2_strt),
    .l2_bsy  (l2_bsy),
    .out_tk  (out_tk),
    .tx_done (tx_done),
    .busy    (busy),
    .iss_cnt (iss_cnt),
    .out_cnt (out_cnt),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},    32'(busy),    0);
    chk({tag, "_iss"},     32'(iss_cnt), 0);
    chk({tag, "_out"},     32'(out_cnt), 0);
    chk({tag, "_strt"},    32'(l2_strt), 0);
    chk({tag, "_ack"},     32'(src_ack), 0);
    chk({tag, "_txdone"},  32'(tx_done), 0);
    chk({tag, "_err"},     32'(err),     0);
  endtask

  // One frame. Cycle k=0 drives frm_go in IDLE; k=1 is the first ISSUE cycle.
  // Pair p issues after its vld gap, busy rises d cycles later for L cycles,
  // and the next ISSUE cycle follows two cycles after busy drops.
  task automatic run_frame(input int gmin, input int gmax, input int dmax,
                           input int lmin, input int lmax, input int tkpct,
                           input bit go_noise, input int abort_pair);
    bit vld [HOR];
    bit bsy [HOR];
    bit tk  [HOR];
    bit go  [HOR];
    bit strt[HOR];
    int c, s, g, d, len, cd, x, n, cdone, abort_k, e_iss, e_out, lim;
    for (int k = 0; k < HOR; k++) begin
      vld[k] = 1'b1; bsy[k] = 1'b0; tk[k] = 1'b0; go[k] = 1'b0; strt[k] = 1'b0;
    end
    abort_k = -1;
    c = 1;
    for (int p = 0; p < int'(N_IN); p++) begin
      g   = int'($urandom_range(gmax, gmin));
      d   = int'($urandom_range(dmax, 0));
      len = int'($urandom_range(lmax, lmin));
      for (int j = c; j < c + g; j++) vld[j] = 1'b0;
      s = c + g;
      strt[s] = 1'b1;
      for (int j = s + 1 + d; j <= s + d + len; j++) bsy[j] = 1'b1;
      if (go_noise) go[s + 1] = 1'b1;
      if (p == abort_pair) abort_k = s + 2;
      c = s + d + len + 2;
    end
    cd = c;
    for (int k = 1; k < HOR; k++) tk[k] = ($urandom_range(99, 0) < tkpct);
    for (int k = cd; k < cd + int'(N_OUT); k++) tk[k] = 1'b1;
    x = -1; n = 0;
    for (int k = 1; k < HOR; k++) begin
      if (x < 0) begin
        n += int'(tk[k]);
        if (n == int'(N_OUT)) x = k;
      end
    end
    cdone = ((x > cd) ? x : cd) + 1;
    if (go_noise)
      for (int k = 1; k <= cdone; k++) if ($urandom_range(4, 0) == 0) go[k] = 1'b1;
    go[0] = 1'b1;

    for (int k = 0; k <= cdone + 1; k++) begin
      if (k == abort_k) begin
        src_vld = vld[k]; l2_bsy = bsy[k]; out_tk = tk[k]; frm_go = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort_async");
        @(negedge clk);
        chk("abort_no_txdone", 32'(tx_done), 0);
        step();
        step();
        rst_n = 1'b1;
        src_vld = 1'b0; l2_bsy = 1'b0; out_tk = 1'b0;
        return;
      end
      frm_go = go[k]; src_vld = vld[k]; l2_bsy = bsy[k]; out_tk = tk[k];
      @(negedge clk);
      chk($sformatf("strt_k%0d", k),   32'(l2_strt), 32'(strt[k]));
      chk($sformatf("ack_k%0d", k),    32'(src_ack), 32'(strt[k]));
      chk($sformatf("txdone_k%0d", k), 32'(tx_done), 32'(k == cdone));
      chk($sformatf("busy_k%0d", k),   32'(busy),    32'(k >= 1 && k <= cdone));
      chk($sformatf("err_k%0d", k),    32'(err),     0);
      if (k >= 1) begin
        e_iss = 0;
        for (int j = 1; j < k; j++) e_iss += int'(strt[j]);
        lim = (k - 1 < cdone - 1) ? k - 1 : cdone - 1;
        e_out = 0;
        for (int j = 1; j <= lim; j++) e_out += int'(tk[j]);
        if (e_out > int'(N_OUT)) e_out = int'(N_OUT);
        chk($sformatf("iss_k%0d", k), 32'(iss_cnt), 32'(e_iss));
        chk($sformatf("out_k%0d", k), 32'(out_cnt), 32'(e_out));
      end
      step();
    end
    frm_go = 1'b0; src_vld = 1'b0; l2_bsy = 1'b0; out_tk = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    out_tk = 1'b1; src_vld = 1'b1; frm_go = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    frm_go = 1'b0; src_vld = 1'b0; out_tk = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Fixed 11-cycle busy windows: issues land exactly 13 cycles apart.
    run_frame(0, 0, 0, 11, 11, 10, 1'b0, -1);
    // Source stalls 20 cycles before every pair.
    run_frame(20, 20, 2, 1, 11, 25, 1'b0, -1);
    // frm_go pulsed in WAIT and elsewhere, dense out_tk to exercise saturation.
    run_frame(0, 3, 2, 1, 11, 70, 1'b1, -1);
    // Reset during WAIT of the second pair, then a clean restart.
    run_frame(0, 2, 2, 1, 11, 30, 1'b0, 1);
    step();
    run_frame(0, 2, 2, 1, 11, 30, 1'b0, -1);
    for (int i = 0; i < 6; i++) run_frame(0, 4, 2, 1, 11, 30, 1'b1, -1);

    // Busy stuck high after the first issue.
    frm_go = 1'b1; src_vld = 1'b1; l2_bsy = 1'b0;
    @(negedge clk);
    step();
    frm_go = 1'b0;
    @(negedge clk);
    chk("wd_strt", 32'(l2_strt), 1);
    step();
    l2_bsy = 1'b1;
    for (int k = 2; k <= 17; k++) begin
      @(negedge clk);
      chk($sformatf("wd_busy_k%0d", k),   32'(busy),    1);
      chk($sformatf("wd_err_k%0d", k),    32'(err),     0);
      chk($sformatf("wd_txdone_k%0d", k), 32'(tx_done), 0);
      step();
    end
`ifdef L2_SEQ_WDOG_EN
    @(negedge clk);
    chk("wd_txdone", 32'(tx_done), 1);
    chk("wd_err_set", 32'(err), 1);
    step();
    @(negedge clk);
    chk("wd_idle", 32'(busy), 0);
    chk("wd_err_sticky", 32'(err), 1);
    chk("wd_txdone_once", 32'(tx_done), 0);
    step();
`else
    for (int k = 18; k <= 40; k++) begin
      @(negedge clk);
      chk($sformatf("nowd_busy_k%0d", k),   32'(busy),    1);
      chk($sformatf("nowd_err_k%0d", k),    32'(err),     0);
      chk($sformatf("nowd_txdone_k%0d", k), 32'(tx_done), 0);
      chk($sformatf("nowd_strt_k%0d", k),   32'(l2_strt), 0);
      step();
    end
`endif
    rst_n = 1'b0;
    #1;
    chk_all_zero("final_reset");
    step();
    rst_n = 1'b1; l2_bsy = 1'b0; src_vld = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/l2_seq_ctrl.md
L2_SEQ_CTRL -- requirements
Module: l2_seq_ctrl

Interface
REQ-001 SHALL have parameter N_IN, default 100; meaning: input pairs issued to the layer-2 datapath per frame; legal range 1..127.
REQ-002 SHALL have parameter N_OUT, default 25; meaning: output groups the downstream consumes per frame; legal range 1..127.
REQ-003 SHALL have parameter WDOG_CYC, default 32; meaning: timeout in cycles for a busy window; legal range 16..255.
REQ-004 SHALL have port clk, input, 1; meaning: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1; meaning: asynchronous active-low reset.
REQ-006 SHALL have port frm_go, input, 1; meaning: start-frame request.
REQ-007 SHALL have port src_vld, input, 1; meaning: upstream din_0/din_1 pair valid.
REQ-008 SHALL have port src_ack, output, 1; meaning: pair-consumed pulse.
REQ-009 SHALL have port l2_strt, output, 1; meaning: start pulse to the datapath.
REQ-010 SHALL have port l2_bsy, input, 1; meaning: datapath busy.
REQ-011 SHALL have port out_tk, input, 1; meaning: downstream consumed one output group (pulse).
REQ-012 SHALL have port tx_done, output, 1; meaning: frame-complete pulse that clears the datapath.
REQ-013 SHALL have port busy, output, 1; meaning: the controller is not in IDLE.
REQ-014 SHALL have port iss_cnt, output, 7; meaning: pairs issued this frame.
REQ-015 SHALL have port out_cnt, output, 7; meaning: groups consumed this frame.
REQ-016 SHALL have port err, output, 1; meaning: sticky watchdog error.

Function
REQ-017 SHALL implement an FSM with states IDLE, ISSUE, WAIT, DRAIN, DONE.
REQ-018 IDLE: on frm_go SHALL clear iss_cnt, out_cnt and the seen-busy flag, then go to ISSUE; frm_go SHALL be ignored in every other state.
REQ-019 ISSUE: if src_vld=1 and l2_bsy=0, SHALL assert l2_strt and src_ack for exactly one cycle, increment iss_cnt and go to WAIT; otherwise SHALL hold in ISSUE.
REQ-020 WAIT: SHALL set the seen-busy flag when l2_bsy=1, and SHALL leave WAIT only when l2_bsy=0 with the flag set; the flag SHALL clear on exit.
REQ-021 WAIT exit: SHALL go to DRAIN if iss_cnt==N_IN, else back to ISSUE; minimum issue-to-issue spacing is therefore bsy window + 2 cycles.
REQ-022 out_cnt SHALL increment on out_tk in ISSUE, WAIT and DRAIN, SHALL saturate at N_OUT, and SHALL ignore out_tk in IDLE and DONE.
REQ-023 DRAIN: when out_cnt==N_OUT (including the increment in the same cycle), SHALL go to DONE.
REQ-024 DONE: SHALL assert tx_done for exactly one cycle, then go to IDLE; iss_cnt and out_cnt SHALL hold their values until the next frm_go.
REQ-025 busy SHALL be 1 in every state except IDLE, combinationally from the state register.
REQ-026 l2_strt, src_ack and tx_done SHALL be registered-free Moore/Mealy decodes with no combinational path from out_tk.
REQ-027 Counters SHALL be 7-bit unsigned with no wrap; N_IN/N_OUT ≤127 guarantees no overflow.

Reset
REQ-028 On rst_n=0, asynchronously: state=IDLE; iss_cnt=0; out_cnt=0; err=0; seen-busy=0; watchdog=0; all pulse outputs=0.
REQ-029 Reset mid-frame SHALL abandon the frame without a tx_done pulse.

Configuration
REQ-030 With L2_SEQ_WDOG_EN defined: an 8-bit watchdog SHALL count cycles in WAIT; reaching WDOG_CYC SHALL set err (sticky until reset) and force DONE, so tx_done still pulses.
REQ-031 Without L2_SEQ_WDOG_EN: no watchdog logic; err SHALL be tied to 0; WAIT is unbounded.

Structure
REQ-032 The package l2_ctrl_pkg SHALL hold the state enum l2_seq_state_t and the default constants for N_IN, N_OUT and WDOG_CYC.
REQ-033 One sub-module, sat_cnt7 (7-bit clear/increment/saturate counter), SHALL be instanced for out_cnt; iss_cnt MAY reuse it.

Verification
REQ-034 N_IN=3, N_OUT=2, src_vld=1, l2_bsy high 11 cycles after each strt, 2 out_tk during the frame -> 3 l2_strt pulses ≥13 cycles apart, one tx_done, iss_cnt=3, out_cnt=2.
REQ-035 src_vld=0 for 20 cycles in ISSUE -> no l2_strt, state held; src_vld rises -> l2_strt on the same cycle.
REQ-036 frm_go pulsed during WAIT, and 5 out_tk pulses with N_OUT=2 -> frm_go ignored; out_cnt saturates at 2.
REQ-037 rst_n low during WAIT of pair 2 -> all outputs 0 immediately, no tx_done; a new frm_go restarts with iss_cnt=0.
REQ-038 L2_SEQ_WDOG_EN defined, WDOG_CYC=16, l2_bsy stuck 1 -> err=1 after 16 WAIT cycles and one tx_done; without the macro, err stays 0 and the FSM stays in WAIT.
